// File: rtl/router_pkg.sv
// Shared constants and types for the 1x3 router datapath, FSM and bench.
package router_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 2;
  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 2;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    LOAD_PARITY,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    WAIT_TILL_EMPTY,
    CHECK_PARITY_ERROR
  } fsm_state_e;

  function automatic logic [LEN_MSB-LEN_LSB:0] hdr_len(input logic [DATA_W-1:0] hdr);
    return hdr[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/router_reg_if.sv
// FSM/source-facing bus of the router register stage.
interface router_reg_if;
  import router_pkg::*;

  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_reg;
  logic [DATA_W-1:0] dout;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              err;

  modport master (
    output pkt_valid, data_in, fifo_full, detect_add, lfd_state,
           ld_state, laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_pkt_valid, err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, detect_add, lfd_state,
           ld_state, laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_pkt_valid, err
  );

endinterface

// File: rtl/router_parity_acc.sv
// Running packet parity, captured parity byte and the mismatch flag.
module router_parity_acc
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              acc_en,
  input  logic [DATA_W-1:0] acc_byte,
  input  logic              cap_en,
  input  logic [DATA_W-1:0] cap_byte,
  input  logic              check_en,
  output logic              err
);

  logic [DATA_W-1:0] int_parity_reg;
  logic [DATA_W-1:0] pkt_parity_reg;
  logic              err_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      int_parity_reg <= '0;
      pkt_parity_reg <= '0;
      err_reg        <= 1'b0;
    end else begin
      if (clear)
        int_parity_reg <= '0;
      else if (acc_en)
        int_parity_reg <= int_parity_reg ^ acc_byte;

      if (cap_en)
        pkt_parity_reg <= cap_byte;

      if (clear)
        err_reg <= 1'b0;
      else if (check_en)
        err_reg <= (int_parity_reg != pkt_parity_reg);
    end
  end

  assign err = err_reg;

endmodule

// File: rtl/router_reg.sv
// Router datapath register: header latch, full-FIFO hold byte and FIFO write data.
module router_reg
  import router_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  router_reg_if.slave  bus
);

  logic [DATA_W-1:0] dout_reg;
  logic [DATA_W-1:0] header_byte_reg;
  logic [DATA_W-1:0] hold_byte_reg;
  logic              parity_done_reg;
  logic              low_pkt_valid_reg;

  logic              acc_en;
  logic [DATA_W-1:0] acc_byte;
  logic              cap_en;
  logic [DATA_W-1:0] cap_byte;

  // Parity controls mirror the transfer priority of the sequential block below.
  always_comb begin
    acc_en   = 1'b0;
    acc_byte = '0;
    cap_en   = 1'b0;
    cap_byte = '0;
    if (bus.lfd_state) begin
      acc_en   = 1'b1;
      acc_byte = header_byte_reg;
    end else if (bus.ld_state) begin
      if (!bus.fifo_full) begin
        if (bus.pkt_valid) begin
          acc_en   = 1'b1;
          acc_byte = bus.data_in;
        end else begin
          cap_en   = 1'b1;
          cap_byte = bus.data_in;
        end
      end
    end else if (bus.laf_state && !parity_done_reg) begin
      if (!low_pkt_valid_reg) begin
        acc_en   = 1'b1;
        acc_byte = hold_byte_reg;
      end else begin
        cap_en   = 1'b1;
        cap_byte = hold_byte_reg;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout_reg          <= '0;
      header_byte_reg   <= '0;
      hold_byte_reg     <= '0;
      parity_done_reg   <= 1'b0;
      low_pkt_valid_reg <= 1'b0;
    end else begin
      if (bus.detect_add && bus.pkt_valid &&
          bus.data_in[ADDR_W-1:0] != ADDR_INVALID)
        header_byte_reg <= bus.data_in;

      if (bus.detect_add)
        parity_done_reg <= 1'b0;

      if (bus.lfd_state) begin
        dout_reg <= header_byte_reg;
      end else if (bus.ld_state) begin
        if (!bus.fifo_full) begin
          dout_reg <= bus.data_in;
          if (!bus.pkt_valid)
            parity_done_reg <= 1'b1;
        end else begin
          hold_byte_reg <= bus.data_in;
        end
      end else if (bus.laf_state && !parity_done_reg) begin
        // The held byte is the parity byte when pkt_valid already dropped.
        dout_reg <= hold_byte_reg;
        if (low_pkt_valid_reg)
          parity_done_reg <= 1'b1;
      end

      if (bus.ld_state && !bus.pkt_valid)
        low_pkt_valid_reg <= 1'b1;
      else if (bus.rst_int_reg)
        low_pkt_valid_reg <= 1'b0;
    end
  end

  router_parity_acc u_parity_acc (
    .clock    (clock),
    .reset    (reset),
    .clear    (bus.detect_add),
    .acc_en   (acc_en),
    .acc_byte (acc_byte),
    .cap_en   (cap_en),
    .cap_byte (cap_byte),
    .check_en (bus.rst_int_reg && parity_done_reg),
    .err      (bus.err)
  );

  assign bus.dout          = dout_reg;
  assign bus.parity_done   = parity_done_reg;
  assign bus.low_pkt_valid = low_pkt_valid_reg;

endmodule

// File: tb/tb_router_reg.sv
// Scoreboard bench for router_reg: stimulus queues timed expectations, a monitor compares.
`timescale 1ns/1ps
module tb_router_reg;
  import router_pkg::*;

  localparam logic [5:0] S_IDLE = 6'b000000;
  localparam logic [5:0] S_DA   = 6'b100000;
  localparam logic [5:0] S_LFD  = 6'b010000;
  localparam logic [5:0] S_LD   = 6'b001000;
  localparam logic [5:0] S_LAF  = 6'b000100;
  localparam logic [5:0] S_FS   = 6'b000010;
  localparam logic [5:0] S_RIR  = 6'b000001;

  localparam int K_DOUT = 0;
  localparam int K_PD   = 1;
  localparam int K_LPV  = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    longint      t;
    int          kind;
    string       name;
    logic [7:0]  exp;
  } exp_t;

  logic clock;
  logic reset;
  router_reg_if bus();

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  router_reg dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic ex(input int k, input string nm, input logic [7:0] v);
    exp_t e;
    e.t    = $time + 1;
    e.kind = k;
    e.name = nm;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [5:0] st, input logic pv, input logic ff, input logic [7:0] d);
    @(negedge clock);
    {bus.detect_add, bus.lfd_state, bus.ld_state,
     bus.laf_state, bus.full_state, bus.rst_int_reg} = st;
    bus.pkt_valid = pv;
    bus.fifo_full = ff;
    bus.data_in   = d;
    @(posedge clock);
  endtask

  // mode 0: normal, 1: FIFO full on second payload, 2: FIFO full on parity byte
  task automatic run_pkt(input logic [7:0] hdr, input logic [7:0] p1, input logic [7:0] p2,
                         input logic [7:0] par, input int mode, input logic exp_err);
    drive(S_DA, 1'b1, 1'b0, hdr);   ex(K_PD, "pd_clr", 8'h00); ex(K_ERR, "err_clr", 8'h00);
    drive(S_LFD, 1'b1, 1'b0, p1);   ex(K_DOUT, "dout_hdr", hdr);
    drive(S_LD, 1'b1, 1'b0, p1);    ex(K_DOUT, "dout_p1", p1);
    if (mode == 1) begin
      drive(S_LD, 1'b1, 1'b1, p2);  ex(K_DOUT, "dout_hold_ld", p1);
      drive(S_FS, 1'b1, 1'b1, p2);  ex(K_DOUT, "dout_hold_fs", p1);
      drive(S_LAF, 1'b1, 1'b0, p2); ex(K_DOUT, "dout_laf_p2", p2); ex(K_PD, "pd_laf", 8'h00);
    end else begin
      drive(S_LD, 1'b1, 1'b0, p2);  ex(K_DOUT, "dout_p2", p2);
    end
    if (mode == 2) begin
      drive(S_LD, 1'b0, 1'b1, par); ex(K_DOUT, "dout_hold_par", p2); ex(K_LPV, "lpv_full", 8'h01);
                                    ex(K_PD, "pd_full", 8'h00);
      drive(S_FS, 1'b0, 1'b1, par); ex(K_DOUT, "dout_fs_par", p2); ex(K_PD, "pd_pre_laf", 8'h00);
      drive(S_LAF, 1'b0, 1'b0, par); ex(K_DOUT, "dout_laf_par", par); ex(K_PD, "pd_post_laf", 8'h01);
    end else begin
      drive(S_LD, 1'b0, 1'b0, par); ex(K_DOUT, "dout_par", par); ex(K_PD, "pd_par", 8'h01);
                                    ex(K_LPV, "lpv_par", 8'h01);
    end
    drive(S_IDLE, 1'b0, 1'b0, par); ex(K_PD, "pd_load_parity", 8'h01);
    drive(S_RIR, 1'b0, 1'b0, par);  ex(K_ERR, "err_check", {7'd0, exp_err});
                                    ex(K_LPV, "lpv_clr", 8'h00);
    if (mode == 1) begin
      drive(S_FS, 1'b0, 1'b0, par);
      drive(S_LAF, 1'b0, 1'b0, par); ex(K_DOUT, "no_extra_write", par);
    end
    drive(S_IDLE, 1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: compares each queued expectation once its sample time arrives.
  initial begin
    logic [7:0] act;
    exp_t e;
    forever begin
      #1;
      while (sb.size() > 0 && sb[0].t <= $time) begin
        e = sb.pop_front();
        case (e.kind)
          K_DOUT:  act = bus.dout;
          K_PD:    act = {7'd0, bus.parity_done};
          K_LPV:   act = {7'd0, bus.low_pkt_valid};
          default: act = {7'd0, bus.err};
        endcase
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
        end else begin
          $display("ok   %s: %h at %0t", e.name, act, $time);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    {bus.detect_add, bus.lfd_state, bus.ld_state,
     bus.laf_state, bus.full_state, bus.rst_int_reg} = S_IDLE;
    bus.pkt_valid = 1'b0;
    bus.fifo_full = 1'b0;
    bus.data_in   = 8'h00;
    #2;
    ex(K_DOUT, "rst_dout", 8'h00); ex(K_PD, "rst_pd", 8'h00);
    ex(K_LPV, "rst_lpv", 8'h00);   ex(K_ERR, "rst_err", 8'h00);
    @(negedge clock);
    reset = 1'b0;

    run_pkt(8'h09, 8'hA5, 8'h3C, 8'h90, 0, 1'b0);
    run_pkt(8'h09, 8'hA5, 8'h3C, 8'h91, 0, 1'b1);
    run_pkt(8'h09, 8'hA5, 8'h3C, 8'h90, 1, 1'b0);
    run_pkt(8'h09, 8'hA5, 8'h3C, 8'h90, 2, 1'b0);

    // Address 3 header is ignored: the previous header 0x09 is replayed.
    drive(S_DA, 1'b1, 1'b0, 8'h0B);  ex(K_DOUT, "dout_da_hold", 8'h90); ex(K_PD, "pd_clr_da", 8'h00);
    drive(S_LFD, 1'b1, 1'b0, 8'h55); ex(K_DOUT, "hdr_retained", 8'h09);
    drive(S_IDLE, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset in the middle of a packet.
    drive(S_DA, 1'b1, 1'b0, 8'h09);
    drive(S_LFD, 1'b1, 1'b0, 8'hA5);
    drive(S_LD, 1'b1, 1'b0, 8'hA5);  ex(K_DOUT, "dout_pre_rst", 8'hA5);
    drive(S_LD, 1'b1, 1'b0, 8'h3C);  ex(K_DOUT, "dout_pre_rst2", 8'h3C);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    ex(K_DOUT, "arst_dout", 8'h00); ex(K_PD, "arst_pd", 8'h00);
    ex(K_LPV, "arst_lpv", 8'h00);   ex(K_ERR, "arst_err", 8'h00);
    @(negedge clock);
    reset = 1'b0;
    run_pkt(8'h09, 8'hA5, 8'h3C, 8'h90, 0, 1'b0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clock);
    #3;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
